// File: rtl/pipe_mux_pkg.sv
// ============================================================================
// Module      : pipe_mux_pkg
// Description : Shared types and constants for the N-input result selector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_mux_pkg;

    localparam int BAD_CNT_W = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

`default_nettype wire

// File: rtl/muxn_comb.sv
// ============================================================================
// Module      : muxn_comb
// Description : Combinational N-input AND-OR selector with out-of-range flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muxn_comb #(
    parameter int  DATA_WIDTH = 64,
    parameter int  NUM_IN     = 5,
    localparam int SEL_W      = $clog2(NUM_IN)
) (
    input  logic [0:NUM_IN-1][DATA_WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]                  sel,
    output logic [DATA_WIDTH-1:0]             data,
    output logic                              bad
);

    logic [NUM_IN-1:0]                 w_hit;
    logic [NUM_IN-1:0][DATA_WIDTH-1:0] w_masked;
    logic [DATA_WIDTH-1:0]             w_or;

    // An unused select code hits no term, so the OR tree yields zero on its own.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_term
            assign w_hit[gi]    = (sel == SEL_W'(gi));
            assign w_masked[gi] = in_data[gi] & {DATA_WIDTH{w_hit[gi]}};
        end
    endgenerate

    always_comb begin
        w_or = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_or = w_or | w_masked[i];
        end
    end

    assign data = w_or;
    assign bad  = (32'(sel) >= 32'(NUM_IN));

endmodule

`default_nettype wire

// File: rtl/pipe_muxn_skid.sv
// ============================================================================
// Module      : pipe_muxn_skid
// Description : N-input result selector with registered 2-entry skid output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_muxn_skid
    import pipe_mux_pkg::*;
#(
    parameter int  DATA_WIDTH = 64,
    parameter int  NUM_IN     = 5,
    localparam int SEL_W      = $clog2(NUM_IN)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [0:NUM_IN-1][DATA_WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]                  in_sel,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_bad_sel,
    output logic [BAD_CNT_W-1:0]              bad_sel_count
);

    skid_state_t           r_state;
    skid_state_t           w_state_next;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_main_data;
    logic                  r_main_bad;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_skid_bad;
    logic [BAD_CNT_W-1:0]  r_bad_cnt;

    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_bad;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_load_main;
    logic                  w_load_skid;
    logic                  w_skid_to_main;

    muxn_comb #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_IN     (NUM_IN)
    ) u_mux (
        .in_data (in_data),
        .sel     (in_sel),
        .data    (w_sel_data),
        .bad     (w_sel_bad)
    );

    // Flush blocks acceptance even when in_ready is high.
    assign w_accept = in_valid && r_in_ready && !flush;
    assign w_pop    = r_out_valid && out_ready;

    always_comb begin
        w_state_next   = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        if (flush) begin
            w_state_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_next = HALF;
                        w_load_main  = 1'b1;
                    end
                end
                HALF: begin
                    if (w_accept && w_pop) begin
                        w_load_main  = 1'b1;
                    end else if (w_accept) begin
                        w_state_next = FULL;
                        w_load_skid  = 1'b1;
                    end else if (w_pop) begin
                        w_state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        w_state_next   = HALF;
                        w_skid_to_main = 1'b1;
                    end
                end
                default: w_state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main_data <= '0;
            r_main_bad  <= 1'b0;
            r_skid_data <= '0;
            r_skid_bad  <= 1'b0;
            r_bad_cnt   <= '0;
        end else begin
            r_state     <= w_state_next;
            // Handshake flags are registered copies of the next state decode.
            r_in_ready  <= (w_state_next != FULL);
            r_out_valid <= (w_state_next != EMPTY);
            if (w_load_main) begin
                r_main_data <= w_sel_data;
                r_main_bad  <= w_sel_bad;
            end else if (w_skid_to_main) begin
                r_main_data <= r_skid_data;
                r_main_bad  <= r_skid_bad;
            end
            if (w_load_skid) begin
                r_skid_data <= w_sel_data;
                r_skid_bad  <= w_sel_bad;
            end
            if (w_accept && w_sel_bad && (r_bad_cnt != '1)) begin
                r_bad_cnt <= r_bad_cnt + 1'b1;
            end
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_data      = r_main_data;
    assign out_bad_sel   = r_main_bad;
    assign bad_sel_count = r_bad_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_muxn_skid.sv
// ============================================================================
// Module      : tb_pipe_muxn_skid
// Description : Self-checking bench for pipe_muxn_skid (NUM_IN=5, 64-bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_muxn_skid;

    localparam int c_dw = 64;
    localparam int c_n  = 5;

    logic                  clk;
    logic                  reset;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [0:c_n-1][c_dw-1:0] in_data;
    logic [2:0]            in_sel;
    logic                  out_valid;
    logic                  out_ready;
    logic [c_dw-1:0]       out_data;
    logic                  out_bad_sel;
    logic [7:0]            bad_sel_count;

    pipe_muxn_skid #(
        .DATA_WIDTH (c_dw),
        .NUM_IN     (c_n)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_sel        (in_sel),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_bad_sel   (out_bad_sel),
        .bad_sel_count (bad_sel_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [c_dw-1:0] d;
        logic            b;
    } ent_t;

    typedef struct {
        logic [2:0]      sel;
        logic [c_dw-1:0] data;
        logic [c_dw-1:0] exp_data;
        logic            exp_bad;
    } vec_t;

    ent_t q[$];
    int   total   = 0;
    int   bad     = 0;
    int   pop_cnt = 0;
    bit   mon_en  = 1'b0;

    task automatic chk(input string name, input logic [c_dw-1:0] act, input logic [c_dw-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < c_n; i++) in_data[i] = {$urandom, $urandom};
    endtask

    // Independent reference for the selected entry.
    function automatic ent_t model();
        ent_t e;
        if (in_sel < 3'(c_n)) begin
            e.d = in_data[in_sel];
            e.b = 1'b0;
        end else begin
            e.d = '0;
            e.b = 1'b1;
        end
        return e;
    endfunction

    // Scoreboard: queue holds the DUT contents as of the last edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("sb_in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("sb_out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                chk("sb_data", out_data, q[0].d);
                chk("sb_bad", 64'(out_bad_sel), 64'(q[0].b));
            end
        end
        if (out_valid === 1'b1 && out_ready && q.size() != 0) begin
            void'(q.pop_front());
            pop_cnt++;
        end
        if (reset || flush) q.delete();
        else if (in_valid && in_ready === 1'b1) q.push_back(model());
    end

    vec_t vecs[8];

    initial begin
        logic [7:0] cnt0;
        int         idx;
        int         pops0;
        bit         saw_full;
        logic       ir0, ov0;

        vecs[0] = '{3'd3, 64'hDEAD,                64'hDEAD,                1'b0};
        vecs[1] = '{3'd0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[2] = '{3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[3] = '{3'd6, 64'h1111,                64'h0,                   1'b1};
        vecs[4] = '{3'd1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b0};
        vecs[5] = '{3'd5, 64'h2222,                64'h0,                   1'b1};
        vecs[6] = '{3'd2, 64'h5A5A_A5A5_0F0F_F0F0, 64'h5A5A_A5A5_0F0F_F0F0, 1'b0};
        vecs[7] = '{3'd7, 64'h3333,                64'h0,                   1'b1};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sel = '0; out_ready = 1'b1;
        rand_data();
        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_bad", 64'(out_bad_sel), 64'd0);
        chk("rst_count", 64'(bad_sel_count), 64'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        // Table vectors, one accept per cycle with output always ready.
        for (int v = 0; v < 8; v++) begin
            rand_data();
            in_valid = 1'b1;
            in_sel   = vecs[v].sel;
            if (vecs[v].sel < 3'(c_n)) in_data[vecs[v].sel] = vecs[v].data;
            tick();
            chk("vec_valid", 64'(out_valid), 64'd1);
            chk("vec_data", out_data, vecs[v].exp_data);
            chk("vec_bad", 64'(out_bad_sel), 64'(vecs[v].exp_bad));
        end
        in_valid = 1'b0;
        tick();
        chk("vec_count", 64'(bad_sel_count), 64'd3);
        tick();

        // Stream 0..9 with a three-cycle downstream stall.
        idx = 0; saw_full = 1'b0; pops0 = pop_cnt; in_sel = 3'd2;
        for (int c = 0; c < 60; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (idx < 10);
            in_data[2] = 64'(idx);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (!in_ready) saw_full = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("stream_accepted", 64'(idx), 64'd10);
        chk("stream_delivered", 64'(pop_cnt - pops0), 64'd10);
        chk("stream_saw_full", 64'(saw_full), 64'd1);

        // Flush while FULL with a simultaneous input offer.
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd1;
        in_data[1] = 64'hAAAA; tick();
        in_data[1] = 64'hBBBB; tick();
        chk("full_in_ready", 64'(in_ready), 64'd0);
        cnt0 = bad_sel_count;
        flush = 1'b1; in_sel = 3'd6; tick();
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("flush_count", 64'(bad_sel_count), 64'(cnt0));
        repeat (2) tick();

        // Reset while HALF.
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd6; tick();
        reset = 1'b1; tick();
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        chk("mrst_out_data", out_data, 64'd0);
        chk("mrst_out_bad", 64'(out_bad_sel), 64'd0);
        chk("mrst_count", 64'(bad_sel_count), 64'd0);
        reset = 1'b0; out_ready = 1'b1; tick();
        chk("count_first", 64'(bad_sel_count), 64'd1);
        repeat (299) tick();
        in_valid = 1'b0; tick();
        chk("count_saturate", 64'(bad_sel_count), 64'd255);

        // Random traffic, including a probe that toggles out_ready mid-cycle.
        for (int c = 0; c < 10000; c++) begin
            rand_data();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_sel    = 3'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 199) == 0);
            #1;
            ir0 = in_ready; ov0 = out_valid;
            out_ready = !out_ready;
            #1;
            chk("comb_in_ready", 64'(in_ready), 64'(ir0));
            chk("comb_out_valid", 64'(out_valid), 64'(ov0));
            out_ready = !out_ready;
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
